// File: rtl/gshare_predictor_pkg.sv
// -----------------------------------------------------------------------------
// gshare_pkg
//   Shared types and helpers for the gshare conditional-branch predictor.
//
//   Contents:
//     predictor_state_t : two-state controller encoding (INIT walk, RUN)
//     weak_nt(cw)       : weakly-not-taken reset value for a cw-bit counter
//     sat_update(...)   : saturating up/down step of a 2..4 bit counter
//
//   Counter helpers work on a 4-bit container (the widest legal counter) and
//   take the real counter width as an argument, so one definition serves
//   every legal C_WIDTH. Callers cast the result back to their own width.
// -----------------------------------------------------------------------------
package gshare_pkg;

    // Widest counter the predictor supports; helper functions use this width.
    localparam int unsigned C_MAX = 4;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } predictor_state_t;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic int weak_nt(input int unsigned cw);
        return (1 << (cw - 1)) - 1;
    endfunction

    // One saturating step towards the resolved outcome.
    function automatic logic [C_MAX-1:0] sat_update(
        input logic [C_MAX-1:0] state,
        input logic             taken,
        input int unsigned      cw = 2
    );
        logic [C_MAX-1:0] max_val;
        logic [C_MAX-1:0] result;
        max_val = C_MAX'((1 << cw) - 1);
        if (taken) begin
            result = (state >= max_val) ? max_val : state + 1'b1;
        end else begin
            result = (state == '0) ? '0 : state - 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// -----------------------------------------------------------------------------
// gshare_predictor_if
//   Bundles the fetch-side lookup port, the prediction result port and the
//   commit-side update/recovery port of the gshare predictor.
//
//   Handshake: there is no backpressure. The predictor accepts a lookup or an
//   update only in a cycle where ready is high. An accepted lookup at edge T
//   produces predValid high for exactly one cycle (T+1), and the consumer must
//   sample prediction/predState/predIndex/predHistory during that cycle; the
//   result is not held. Update and mispredict are single-cycle pulses.
//
//   Modports:
//     master : fetch/commit logic (drives requests, receives predictions)
//     slave  : the predictor
// -----------------------------------------------------------------------------
interface gshare_predictor_if #(
    parameter int I_WIDTH = 8,
    parameter int C_WIDTH = 2,
    parameter int H_WIDTH = 8
);
    // Lookup request
    logic               lookupValid;
    logic [I_WIDTH-1:0] pc;

    // Prediction result
    logic               predValid;
    logic               prediction;
    logic [C_WIDTH-1:0] predState;
    logic [I_WIDTH-1:0] predIndex;
    logic [H_WIDTH-1:0] predHistory;
    logic               ready;

    // Commit-time update and history recovery
    logic               updateValid;
    logic [I_WIDTH-1:0] updateIndex;
    logic [C_WIDTH-1:0] updateState;
    logic               updateTaken;
    logic               mispredict;
    logic [H_WIDTH-1:0] recoverHistory;
    logic               recoverTaken;

    modport master (
        output lookupValid, pc,
        output updateValid, updateIndex, updateState, updateTaken,
        output mispredict, recoverHistory, recoverTaken,
        input  predValid, prediction, predState, predIndex, predHistory, ready
    );

    modport slave (
        input  lookupValid, pc,
        input  updateValid, updateIndex, updateState, updateTaken,
        input  mispredict, recoverHistory, recoverTaken,
        output predValid, prediction, predState, predIndex, predHistory, ready
    );

endinterface

// File: rtl/gshare_predictor_pattern_table.sv
// -----------------------------------------------------------------------------
// pattern_table
//   2^ADDR_W x DATA_W pattern history table: one synchronous read port, one
//   write port, write-first bypass when both ports address the same entry in
//   the same cycle. Storage has no reset (it is initialised by the owner's
//   walk); only the read data register is cleared so outputs are 0 in reset.
//
//   Ports:
//     clk, reset : clock, synchronous active-high reset (read register only)
//     rd_en      : capture a read this cycle
//     rd_addr    : read address
//     rd_data    : registered read data, valid the cycle after rd_en
//     wr_en      : write enable
//     wr_addr    : write address
//     wr_data    : write data
// -----------------------------------------------------------------------------
module pattern_table #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-address write in the read cycle wins, so a commit update is
    // visible to a lookup issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_q <= wr_data;
            end else begin
                rd_q <= mem[rd_addr];
            end
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//   Gshare conditional-branch predictor for the fetch stage. Owns the global
//   history register (GHR): it is shifted speculatively with each prediction
//   and restored from commit on a mispredict. Counter updates are computed
//   internally from the committed outcome. After reset the pattern table is
//   walked once, writing weakly-not-taken into every entry, before ready rises.
//
//   Ports:
//     clk       : single clock, all state on posedge
//     reset     : synchronous active-high; restarts the init walk, clears GHR
//     bus       : gshare_predictor_if.slave (lookup, prediction, update,
//                 recovery signals; see the interface for the handshake)
//     fsm_state : current controller state, for observation only
//
//   Parameters:
//     I_WIDTH : index width, table depth 2^I_WIDTH
//     C_WIDTH : counter width, 2..4
//     H_WIDTH : history length, 1..I_WIDTH (zero-extended for hashing)
// -----------------------------------------------------------------------------
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int I_WIDTH = 8,
    parameter int C_WIDTH = 2,
    parameter int H_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    gshare_predictor_if.slave      bus,
    output predictor_state_t       fsm_state
);

    localparam logic [C_WIDTH-1:0] WEAK_NT  = C_WIDTH'(weak_nt(C_WIDTH));
    localparam logic [I_WIDTH-1:0] PTR_LAST = '1;

    // Controller and walk pointer
    predictor_state_t   state_q;
    predictor_state_t   state_next;
    logic [I_WIDTH-1:0] ptr_q;

    // History
    logic [H_WIDTH-1:0] ghr_q;
    logic [H_WIDTH-1:0] hist_shift;
    logic [H_WIDTH-1:0] hist_eff;
    logic [H_WIDTH-1:0] recover_shift;

    // Lookup pipeline
    logic               lookup_accept;
    logic [I_WIDTH-1:0] lookup_index;
    logic               pred_valid_q;
    logic [I_WIDTH-1:0] pred_index_q;
    logic [H_WIDTH-1:0] pred_history_q;

    // Table ports
    logic               wr_en;
    logic [I_WIDTH-1:0] wr_addr;
    logic [C_WIDTH-1:0] wr_data;
    logic [C_WIDTH-1:0] rd_data;

    // -------------------------------------------------------------------------
    // History shift helpers. With a one-bit history the shifted value is just
    // the new outcome bit.
    // -------------------------------------------------------------------------
    generate
        if (H_WIDTH == 1) begin : g_hist1
            assign hist_shift    = rd_data[C_WIDTH-1];
            assign recover_shift = bus.recoverTaken;
        end else begin : g_histn
            assign hist_shift    = {ghr_q[H_WIDTH-2:0], rd_data[C_WIDTH-1]};
            assign recover_shift = {bus.recoverHistory[H_WIDTH-2:0], bus.recoverTaken};
        end
    endgenerate

    // The previous branch's prediction has not reached the GHR yet while it is
    // on the outputs; fold it in here so back-to-back lookups see it.
    assign hist_eff = pred_valid_q ? hist_shift : ghr_q;

    assign lookup_index  = bus.pc ^ I_WIDTH'(hist_eff);

    // A lookup in the mispredict cycle is on the wrong path and is dropped.
    assign lookup_accept = (state_q == RUN) && bus.lookupValid && !bus.mispredict;

    // -------------------------------------------------------------------------
    // Controller: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Controller: next state and table write mux (init walk vs commit update)
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        wr_en      = 1'b0;
        wr_addr    = ptr_q;
        wr_data    = WEAK_NT;
        case (state_q)
            INIT: begin
                wr_en = !reset;
                if (ptr_q == PTR_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                wr_en   = !reset && bus.updateValid;
                wr_addr = bus.updateIndex;
                wr_data = C_WIDTH'(sat_update(C_MAX'(bus.updateState),
                                              bus.updateTaken, C_WIDTH));
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Init walk pointer: one entry per cycle while in INIT
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (state_q == INIT) begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // GHR: recovery beats the speculative shift of a prediction on the outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (state_q == RUN) begin
            if (bus.mispredict) begin
                ghr_q <= recover_shift;
            end else if (pred_valid_q) begin
                ghr_q <= hist_shift;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Prediction output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q   <= 1'b0;
            pred_index_q   <= '0;
            pred_history_q <= '0;
        end else begin
            pred_valid_q <= lookup_accept;
            if (lookup_accept) begin
                pred_index_q   <= lookup_index;
                pred_history_q <= hist_eff;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pattern history table
    // -------------------------------------------------------------------------
    pattern_table #(
        .ADDR_W (I_WIDTH),
        .DATA_W (C_WIDTH)
    ) u_pattern_table (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (lookup_accept),
        .rd_addr (lookup_index),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign bus.ready       = (state_q == RUN);
    assign bus.predValid   = pred_valid_q;
    assign bus.predState   = rd_data;
    assign bus.prediction  = rd_data[C_WIDTH-1];
    assign bus.predIndex   = pred_index_q;
    assign bus.predHistory = pred_history_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
//   Directed bench for gshare_predictor at default parameters (I=8, C=2, H=8).
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;
    import gshare_pkg::*;

    logic clk;
    logic reset;
    predictor_state_t fsm_state;

    int checks;
    int failures;

    gshare_predictor_if #(.I_WIDTH(8), .C_WIDTH(2), .H_WIDTH(8)) bus ();

    gshare_predictor #(.I_WIDTH(8), .C_WIDTH(2), .H_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with an optional lookup and an optional update.
    task automatic cycle(input logic lv, input logic [7:0] pcv,
                         input logic uv, input logic [7:0] uidx,
                         input logic [1:0] ust, input logic utk);
        bus.lookupValid = lv;
        bus.pc          = pcv;
        bus.updateValid = uv;
        bus.updateIndex = uidx;
        bus.updateState = ust;
        bus.updateTaken = utk;
        step();
        bus.lookupValid = 1'b0;
        bus.updateValid = 1'b0;
    endtask

    // Force GHR to zero via a recovery with zero history and not-taken.
    task automatic clear_ghr();
        bus.mispredict     = 1'b1;
        bus.recoverHistory = 8'h00;
        bus.recoverTaken   = 1'b0;
        step();
        bus.mispredict     = 1'b0;
    endtask

    // Release reset and run out the init walk, checking ready timing.
    task automatic walk(input string tag);
        logic early_ready;
        logic early_valid;
        early_ready = 1'b0;
        early_valid = 1'b0;
        reset = 1'b0;
        bus.lookupValid = 1'b1;
        bus.pc          = 8'h00;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (bus.ready !== 1'b0) early_ready = 1'b1;
            if (bus.predValid !== 1'b0) early_valid = 1'b1;
        end
        bus.lookupValid = 1'b0;
        check({tag, "_ready_low_255"}, 32'(early_ready), 32'd0);
        check({tag, "_no_valid_in_init"}, 32'(early_valid), 32'd0);
        step();
        check({tag, "_ready_at_256"}, 32'(bus.ready), 32'd1);
        check({tag, "_state_run"}, 32'(fsm_state), 32'(RUN));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.lookupValid    = 1'b0;
        bus.pc             = '0;
        bus.updateValid    = 1'b0;
        bus.updateIndex    = '0;
        bus.updateState    = '0;
        bus.updateTaken    = 1'b0;
        bus.mispredict     = 1'b0;
        bus.recoverHistory = '0;
        bus.recoverTaken   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_pred_valid", 32'(bus.predValid), 32'd0);
        check("rst_pred_state", 32'(bus.predState), 32'd0);
        check("rst_pred_index", 32'(bus.predIndex), 32'd0);
        check("rst_fsm_init", 32'(fsm_state), 32'(INIT));

        // Init walk with lookups held high throughout
        walk("init");

        // First lookup after init: weakly not taken everywhere
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0);
        check("idle_valid", 32'(bus.predValid), 32'd1);
        check("idle_state", 32'(bus.predState), 32'd1);
        check("idle_prediction", 32'(bus.prediction), 32'd0);
        check("idle_index", 32'(bus.predIndex), 32'h00);
        step();
        check("idle_valid_one_cycle", 32'(bus.predValid), 32'd0);

        // Saturation chain at 0x05, observed through read-during-write
        cycle(1'b1, 8'h05, 1'b1, 8'h05, 2'b01, 1'b1);
        check("sat_01_to_10", 32'(bus.predState), 32'd2);
        clear_ghr();
        check("sat_flush_valid", 32'(bus.predValid), 32'd0);
        cycle(1'b1, 8'h05, 1'b1, 8'h05, 2'b10, 1'b1);
        check("sat_10_to_11", 32'(bus.predState), 32'd3);
        clear_ghr();
        cycle(1'b1, 8'h05, 1'b1, 8'h05, 2'b11, 1'b1);
        check("sat_11_stays", 32'(bus.predState), 32'd3);
        clear_ghr();
        cycle(1'b1, 8'h05, 1'b0, 8'h00, 2'b00, 1'b0);
        check("sat_lookup_state", 32'(bus.predState), 32'd3);
        check("sat_lookup_pred", 32'(bus.prediction), 32'd1);
        check("sat_lookup_index", 32'(bus.predIndex), 32'h05);
        clear_ghr();

        // Not-taken floor and a plain decrement
        cycle(1'b1, 8'h06, 1'b1, 8'h06, 2'b00, 1'b0);
        check("nt_00_stays", 32'(bus.predState), 32'd0);
        check("nt_00_pred", 32'(bus.prediction), 32'd0);
        clear_ghr();
        cycle(1'b1, 8'h07, 1'b1, 8'h07, 2'b11, 1'b0);
        check("nt_11_to_10", 32'(bus.predState), 32'd2);
        clear_ghr();

        // Read-during-write at 0x33
        cycle(1'b1, 8'h33, 1'b1, 8'h33, 2'b01, 1'b1);
        check("rdw_state", 32'(bus.predState), 32'd2);
        check("rdw_index", 32'(bus.predIndex), 32'h33);
        clear_ghr();

        // Speculative history: train 0x10 to strongly taken, then back-to-back
        cycle(1'b0, 8'h00, 1'b1, 8'h10, 2'b11, 1'b1);
        cycle(1'b1, 8'h10, 1'b0, 8'h00, 2'b00, 1'b0);
        check("spec_first_state", 32'(bus.predState), 32'd3);
        check("spec_first_index", 32'(bus.predIndex), 32'h10);
        cycle(1'b1, 8'h20, 1'b0, 8'h00, 2'b00, 1'b0);
        check("spec_second_index", 32'(bus.predIndex), 32'h21);
        check("spec_second_history", 32'(bus.predHistory), 32'h01);
        check("spec_second_state", 32'(bus.predState), 32'd1);

        // Mispredict with a same-cycle lookup and an independent update
        bus.mispredict     = 1'b1;
        bus.recoverHistory = 8'h0F;
        bus.recoverTaken   = 1'b0;
        cycle(1'b1, 8'h55, 1'b1, 8'h40, 2'b11, 1'b0);
        bus.mispredict     = 1'b0;
        check("misp_lookup_dropped", 32'(bus.predValid), 32'd0);
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0);
        check("misp_next_valid", 32'(bus.predValid), 32'd1);
        check("misp_next_index", 32'(bus.predIndex), 32'h1E);
        check("misp_next_history", 32'(bus.predHistory), 32'h1E);
        clear_ghr();
        cycle(1'b1, 8'h40, 1'b0, 8'h00, 2'b00, 1'b0);
        check("misp_update_applied", 32'(bus.predState), 32'd2);
        clear_ghr();

        // Reset mid-walk at pointer 100, then a full walk
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
        end
        check("midwalk_still_init", 32'(bus.ready), 32'd0);
        reset = 1'b1;
        step();
        check("midwalk_rst_ready", 32'(bus.ready), 32'd0);
        check("midwalk_rst_fsm", 32'(fsm_state), 32'(INIT));
        walk("rewalk");
        cycle(1'b1, 8'h05, 1'b0, 8'h00, 2'b00, 1'b0);
        check("rewalk_trained_cleared", 32'(bus.predState), 32'd1);
        check("rewalk_pred", 32'(bus.prediction), 32'd0);
        check("rewalk_index", 32'(bus.predIndex), 32'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
